// File: rtl/hilo_ctrl.sv
// E-stage front end for the multiply/divide unit: issues MULT/DIV operations, enforces the
// architectural minimum latency, and owns the HI/LO registers read by MFHI/MFLO.
module hilo_ctrl #(
    parameter int unsigned MUL_CYCLES = 5,
    parameter int unsigned DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_start,
    input  logic [2:0]  e_op,
    input  logic [31:0] e_src0,
    input  logic [31:0] e_src1,
    input  logic        e_cancel,
    input  logic        rd_hi,
    output logic [31:0] hilo_rdata,
    output logic        busy,
    output logic [31:0] mu_src0,
    output logic [31:0] mu_src1,
    output logic [1:0]  mu_op,
    output logic        mu_sign,
    output logic        mu_in_valid,
    input  logic        mu_in_ready,
    input  logic        mu_out_valid,
    output logic        mu_out_ready,
    input  logic [31:0] mu_res0,
    input  logic [31:0] mu_res1
);

    localparam int unsigned MaxCycles = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [2:0] OpMult  = 3'd1;
    localparam logic [2:0] OpMultu = 3'd2;
    localparam logic [2:0] OpDiv   = 3'd3;
    localparam logic [2:0] OpDivu  = 3'd4;
    localparam logic [2:0] OpMthi  = 3'd5;
    localparam logic [2:0] OpMtlo  = 3'd6;

    localparam logic [1:0] MuIdle = 2'b00;
    localparam logic [1:0] MuMul  = 2'b01;
    localparam logic [1:0] MuDiv  = 2'b10;

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDz} state_e;

    state_e          state_q;
    logic [31:0]     hi_q, lo_q;
    logic [31:0]     buf_hi_q, buf_lo_q;
    logic            captured_q;
    logic [CntW-1:0] cnt_q;
    logic [31:0]     src0_q, src1_q;
    logic [1:0]      op_q;
    logic            sign_q;

    logic accept, is_div, is_muldiv, res_hs, cnt_done;

    assign accept    = e_start && !e_cancel && (e_op >= OpMult) && (e_op <= OpMtlo);
    assign is_div    = (e_op == OpDiv) || (e_op == OpDivu);
    assign is_muldiv = (e_op == OpMult) || (e_op == OpMultu) || is_div;
    assign res_hs    = mu_out_valid && mu_out_ready;
    assign cnt_done  = cnt_q <= CntW'(1);

    assign busy         = state_q != StIdle;
    assign mu_in_valid  = state_q == StIssue;
    assign mu_out_ready = (state_q == StWait) && !captured_q;
    assign mu_src0      = src0_q;
    assign mu_src1      = src1_q;
    assign mu_op        = op_q;
    assign mu_sign      = sign_q;
    assign hilo_rdata   = rd_hi ? hi_q : lo_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            hi_q       <= '0;
            lo_q       <= '0;
            buf_hi_q   <= '0;
            buf_lo_q   <= '0;
            captured_q <= 1'b0;
            cnt_q      <= '0;
            src0_q     <= '0;
            src1_q     <= '0;
            op_q       <= MuIdle;
            sign_q     <= 1'b0;
        end else begin
            if (state_q != StIdle && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (accept && e_op == OpMthi) begin
                        hi_q <= e_src0;
                    end else if (accept && e_op == OpMtlo) begin
                        lo_q <= e_src0;
                    end else if (accept && is_muldiv) begin
                        src0_q  <= e_src0;
                        src1_q  <= e_src1;
                        op_q    <= is_div ? MuDiv : MuMul;
                        sign_q  <= (e_op == OpMult) || (e_op == OpDiv);
                        cnt_q   <= is_div ? CntW'(DIV_CYCLES) : CntW'(MUL_CYCLES);
                        // Divide-by-zero never reaches the unit; it only burns the latency.
                        state_q <= (is_div && e_src1 == '0) ? StDz : StIssue;
                    end
                end
                StIssue: begin
                    if (mu_in_ready) begin
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_done && (captured_q || res_hs)) begin
                        hi_q       <= captured_q ? buf_hi_q : mu_res1;
                        lo_q       <= captured_q ? buf_lo_q : mu_res0;
                        captured_q <= 1'b0;
                        op_q       <= MuIdle;
                        state_q    <= StIdle;
                    end else if (res_hs) begin
                        buf_hi_q   <= mu_res1;
                        buf_lo_q   <= mu_res0;
                        captured_q <= 1'b1;
                    end
                end
                StDz: begin
                    if (cnt_done) begin
                        op_q    <= MuIdle;
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- E-stage front end for the multiply/divide unit, located between the pipeline's E stage and the mul/div unit.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO requests and issues operations to the unit over its valid/ready handshake.
- Drains the unit's result, enforces the architectural minimum latency, and owns the HI/LO registers.
- Provides the `busy` stall signal and the HI/LO read data used by MFHI/MFLO.

Parameters:
- MUL_CYCLES, 5, minimum cycles `busy` stays high for MULT/MULTU (must be ≥2).
- DIV_CYCLES, 10, minimum cycles `busy` stays high for DIV/DIVU (must be ≥2).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- e_start  input  1  request valid in E this cycle
- e_op  input  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- e_src0  input  32  rs value
- e_src1  input  32  rt value
- e_cancel  input  1  kill the E request (exception/interrupt in a later stage)
- rd_hi  input  1  1 selects HI, 0 selects LO
- hilo_rdata  output  32  committed HI or LO, combinational from the registers
- busy  output  1  high while a mult/div operation is in flight
- mu_src0, mu_src1  output  32  operands to the unit
- mu_op  output  2  2'b01 MUL, 2'b10 DIV, 2'b00 idle
- mu_sign  output  1  signed operation
- mu_in_valid  output  1
- mu_in_ready  input  1
- mu_out_valid  input  1
- mu_out_ready  output  1
- mu_res0  input  32  LO part (product low or quotient)
- mu_res1  input  32  HI part (product high or remainder)

Behaviour:

Reset:
- State IDLE; HI and LO are 0; `busy` 0; mu_in_valid 0; mu_out_ready 0; mu_op 0; mu_src0 and mu_src1 0; internal counter 0; result-captured flag 0.
- Reset mid-operation abandons the operation; HI and LO go to 0. The unit shares the same reset.

Request acceptance (only in IDLE):
- An E request is accepted when e_start=1, e_cancel=0, and e_op is 1–6.
- MTHI/MTLO write e_src0 into HI/LO at the same edge. State stays IDLE and `busy` stays 0.
- MULT/MULTU/DIV/DIVU at the same edge:
  - Latch operands, mu_op and mu_sign (MULT and DIV are signed).
  - Load the counter with MUL_CYCLES or DIV_CYCLES.
  - Go to ISSUE.
- DIV/DIVU with e_src1==0 goes to state DZ instead of ISSUE and issues nothing to the unit.
- e_start while not IDLE is ignored; the pipeline must stall on `busy`.
- e_cancel=1 suppresses every effect of that request.

States:
- ISSUE:
  - mu_in_valid=1 with stable mu_src0, mu_src1, mu_op and mu_sign.
  - Moves to WAIT on mu_in_valid & mu_in_ready.
- WAIT:
  - mu_out_ready = !captured.
  - On mu_out_valid & mu_out_ready, capture {res1,res0} into a buffer and set `captured`.
- DZ: waits for the counter only; HI and LO are left unchanged.

Counter:
- Decrements by 1 each cycle in ISSUE, WAIT and DZ while greater than 0.
- Commit condition, evaluated in WAIT: counter ≤1 AND (`captured` OR a result handshake this cycle).
- On commit:
  - HI := res1 and LO := res0; the arriving result is bypassed if not yet captured.
  - Clear `captured`.
  - Go to IDLE.
- DZ returns to IDLE when counter ≤1, with no write.

Busy and latency:
- `busy` = (state ≠ IDLE), so it rises the cycle after acceptance.
- With a unit responding in ≤ N−1 cycles, `busy` is high for exactly N cycles (N = MUL_CYCLES or DIV_CYCLES).
- With a slower unit, `busy` extends until the commit.

Read port:
- hilo_rdata reflects only committed values.
- A write to HI/LO is visible in the cycle after its edge. There is no bypass of in-flight writes.

Test Plan:
- MULT with e_src0=0xFFFFFFFD (−3), e_src1=5, unit responding next cycle -> `busy` high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1; exactly one mu_in_valid handshake.
- MULTU with 0xFFFFFFFF × 2 -> HI=0x00000001, LO=0xFFFFFFFE; mu_sign=0.
- DIV with −7 / 2, unit returns quotient in res0 and remainder in res1 -> HI=0xFFFFFFFF, LO=0xFFFFFFFD; `busy` high 10 cycles.
- DIVU with e_src1=0 and HI/LO preloaded to 0x11/0x22 via MTHI/MTLO -> mu_in_valid never asserts; `busy` high 10 cycles; HI=0x11, LO=0x22 unchanged; rd_hi=1 reads 0x11.
- Slow unit (mu_in_ready held 0 for 3 cycles, mu_out_valid 8 cycles later) on MULT -> `busy` extends past 5 cycles and falls the cycle after commit; e_start pulses during `busy` are ignored.
- Cancel and reset cases:
  - MULT with e_cancel=1 -> no state change and `busy` stays 0.
  - Reset asserted in WAIT -> next cycle IDLE, HI=LO=0, mu_in_valid=0.
